udp_tx_scheduler: RTL and testbench
===================================

UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16'd65527, maximum accepted payload length in bytes.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports reqN_valid  input  1  request N pending, for N = 0, 1.
REQ-005 The block SHALL have ports reqN_ready  output  1  request N accepted this cycle.
REQ-006 The block SHALL have ports reqN_src, reqN_dst, reqN_len, reqN_csum  input  16 each  source port, destination port, payload bytes, checksum.
REQ-007 The block SHALL have port hdr_valid  output  1  header word presented.
REQ-008 The block SHALL have port hdr_ready  input  1  downstream takes the header.
REQ-009 The block SHALL have port hdr_data  output  64  {src, dst, udp_length, csum}, MSB first.
REQ-010 The block SHALL have port hdr_sel  output  1  index of the granted requester.
REQ-011 The block SHALL have port pay_beat  input  1  downstream consumed one 8-byte payload beat.
REQ-012 The block SHALL have port pay_active  output  1  payload phase in progress.
REQ-013 The block SHALL have port pay_last  output  1  current beat is the final one.
REQ-014 The block SHALL have port err_len  output  1  one-cycle pulse when an oversize request is dropped.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, HDR and PAY.
REQ-016 In IDLE with one valid requester, the block SHALL grant it. With both valid, it SHALL grant the one not granted last (round-robin pointer).
REQ-017 reqN_ready SHALL be combinational and high only in IDLE for the granted requester. At most one ready SHALL be high per cycle.
REQ-018 On acceptance, the block SHALL latch src, dst, len and csum, set hdr_sel, and flip the pointer away from the granted requester.
REQ-019 If the latched len > MAX_LEN, the block SHALL pulse err_len on the next cycle and remain in IDLE. No header SHALL be issued.
REQ-020 Otherwise the FSM SHALL enter HDR, with hdr_valid high on the cycle after acceptance (1-cycle latency).
REQ-021 In HDR, hdr_data SHALL equal {src, dst, len+16'd8, csum}, held stable until the hdr_valid && hdr_ready handshake.
REQ-022 On the HDR handshake with len == 0, the FSM SHALL return to IDLE. Otherwise it SHALL enter PAY with beat count = (len+7)>>3, computed at 17-bit width.
REQ-023 In PAY, pay_active SHALL be 1 and pay_last SHALL equal (count == 1).
REQ-024 In PAY, each pay_beat SHALL decrement the count. A pay_beat with count == 1 SHALL return the FSM to IDLE.
REQ-025 pay_beat outside PAY SHALL be ignored.
REQ-026 hdr_sel SHALL hold its value from acceptance until the next acceptance.
REQ-027 A request arriving while the FSM is not in IDLE SHALL wait, with ready low. Its inputs SHALL not be sampled until it is granted.

Reset
REQ-028 On rst low, the block SHALL asynchronously force: state IDLE, pointer favouring req0, hdr_valid 0, hdr_data 0, hdr_sel 0, pay_active 0, pay_last 0, err_len 0, count 0.
REQ-029 Reset asserted mid-HDR or mid-PAY SHALL abandon the transfer. No output pulse SHALL follow release.
REQ-030 The first grant after release SHALL be req0 if both requesters are valid.

Structure
REQ-031 A shared package udp_pkg SHALL hold: state encoding, UDP_HDR_BYTES = 8, BEAT_BYTES = 8, and the 64-bit header field offsets.
REQ-032 Header packing and length arithmetic SHALL be a sub-module udp_hdr_pack (latched fields in -> hdr_data, beat count out).
REQ-033 Arbitration and the FSM SHALL reside in udp_tx_scheduler.

Verification
REQ-034 The bench SHALL drive req0 only, with src ABCD, dst BCDE, len 0010, csum 0123. Required response: hdr_data = ABCD_BCDE_0018_0123 the cycle after ready, then two pay_beats with pay_last on the second, then IDLE.
REQ-035 The bench SHALL hold req0 and req1 valid continuously. Required response: grants alternate 0, 1, 0, 1 and hdr_sel matches each grant.
REQ-036 The bench SHALL drive req1 with len 0000. Required response: header 0008 in the length field, pay_active never asserts, return to IDLE on hdr_ready.
REQ-037 The bench SHALL drive req0 with len FFF0. Required response: ready high, err_len pulses once, no hdr_valid, pointer advances.
REQ-038 The bench SHALL hold hdr_ready low for 5 cycles. Required response: hdr_data stable and the other requester not granted.
REQ-039 The bench SHALL assert rst low during PAY with count 3. Required response: all outputs 0 immediately, and req0 is granted first after release.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit scheduler.
// Header layout is {src, dst, udp_length, csum}, MSB first.
package udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_e;

  localparam int UDP_HDR_BYTES = 8;
  localparam int BEAT_BYTES    = 8;

  localparam int SRC_LSB  = 48;
  localparam int DST_LSB  = 32;
  localparam int LEN_LSB  = 16;
  localparam int CSUM_LSB = 0;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [15:0] csum;
  } udp_req_t;

endpackage

// File: rtl/udp_hdr_pack.sv
// Packs latched request fields into the 64-bit UDP header word
// and derives the payload beat count.
module udp_hdr_pack
  import udp_pkg::*;
(
  input  udp_req_t    req,
  output logic [63:0] hdr_word,
  output logic [15:0] beats
);

  logic [16:0] len_rnd;

  // 17 bits so a 0xFFFF length cannot wrap before the shift
  assign len_rnd = {1'b0, req.len} + 17'(BEAT_BYTES - 1);
  assign beats   = 16'(len_rnd >> $clog2(BEAT_BYTES));

  always_comb begin
    hdr_word = '0;
    hdr_word[SRC_LSB  +: 16] = req.src;
    hdr_word[DST_LSB  +: 16] = req.dst;
    hdr_word[LEN_LSB  +: 16] = req.len + 16'(UDP_HDR_BYTES);
    hdr_word[CSUM_LSB +: 16] = req.csum;
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Two-requester round-robin UDP header/payload scheduler.
// Oversize requests are consumed and flagged on err_len.
module udp_tx_scheduler
  import udp_pkg::*;
#(
  parameter logic [15:0] MAX_LEN = 16'd65527
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_src,
  input  logic [15:0] req0_dst,
  input  logic [15:0] req0_len,
  input  logic [15:0] req0_csum,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_src,
  input  logic [15:0] req1_dst,
  input  logic [15:0] req1_len,
  input  logic [15:0] req1_csum,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [63:0] hdr_data,
  output logic        hdr_sel,
  input  logic        pay_beat,
  output logic        pay_active,
  output logic        pay_last,
  output logic        err_len
);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  udp_req_t    fld_q, fld_d;
  logic        sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        gnt;
  logic        accept;
  udp_req_t    req_mux;
  logic [63:0] hdr_word;
  logic [15:0] beats;

  // ptr_q == 0 favours req0 when both are pending
  assign gnt    = (req0_valid & req1_valid) ? ptr_q : req1_valid;
  assign accept = rst & (req0_valid | req1_valid)
                & (state_q == ST_IDLE);

  assign req0_ready = accept & ~gnt;
  assign req1_ready = accept & gnt;

  assign req_mux = gnt
    ? '{req1_src, req1_dst, req1_len, req1_csum}
    : '{req0_src, req0_dst, req0_len, req0_csum};

  udp_hdr_pack u_pack (
    .req      (fld_q),
    .hdr_word (hdr_word),
    .beats    (beats)
  );

  assign hdr_valid  = (state_q == ST_HDR);
  assign hdr_data   = hdr_valid ? hdr_word : '0;
  assign hdr_sel    = sel_q;
  assign pay_active = (state_q == ST_PAY);
  assign pay_last   = pay_active & (cnt_q == 16'd1);
  assign err_len    = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fld_d   = fld_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          fld_d = req_mux;
          sel_d = gnt;
          ptr_d = ~gnt;
          if (req_mux.len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (hdr_ready) begin
          if (fld_q.len == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAY;
            cnt_d   = beats;
          end
        end
      end
      ST_PAY: begin
        if (pay_beat) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      fld_q   <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fld_q   <= fld_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed and randomized bench for udp_tx_scheduler.
module tb_udp_tx_scheduler;

  localparam logic [15:0] MAXL = 16'd1472;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_src, req0_dst, req0_len, req0_csum;
  logic [15:0] req1_src, req1_dst, req1_len, req1_csum;
  logic        hdr_valid, hdr_ready;
  logic [63:0] hdr_data;
  logic        hdr_sel;
  logic        pay_beat, pay_active, pay_last, err_len;

  int errors = 0;
  int checks = 0;

  udp_tx_scheduler #(.MAX_LEN(MAXL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_src   (req0_src),
    .req0_dst   (req0_dst),
    .req0_len   (req0_len),
    .req0_csum  (req0_csum),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_src   (req1_src),
    .req1_dst   (req1_dst),
    .req1_len   (req1_len),
    .req1_csum  (req1_csum),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .hdr_data   (hdr_data),
    .hdr_sel    (hdr_sel),
    .pay_beat   (pay_beat),
    .pay_active (pay_active),
    .pay_last   (pay_last),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [15:0] s, d, l, c);
    req0_src = s; req0_dst = d; req0_len = l; req0_csum = c;
  endtask

  task automatic set_req1(input logic [15:0] s, d, l, c);
    req1_src = s; req1_dst = d; req1_len = l; req1_csum = c;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, hdr_valid, hdr_sel,
         pay_active, pay_last, err_len} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0", {req0_ready,
        req1_ready, hdr_valid, hdr_sel, pay_active,
        pay_last, err_len});
    end
    checks++;
    if (hdr_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", hdr_data);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    set_req0(16'hABCD, 16'hBCDE, 16'h0010, 16'h0123);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_rdy got %b exp 10",
        {req0_ready, req1_ready});
    end
    cyc();
    req0_valid = 1'b0;
    #1;
    checks++;
    if (hdr_valid !== 1'b1 ||
        hdr_data !== 64'hABCD_BCDE_0018_0123 ||
        hdr_sel !== 1'b0) begin
      errors++;
      $display("FAIL single_hdr got v=%b %h sel=%b exp 1 %h 0",
        hdr_valid, hdr_data, hdr_sel, 64'hABCD_BCDE_0018_0123);
    end
    hdr_ready = 1'b1;
    cyc();
    hdr_ready = 1'b0;
    #1;
    checks++;
    if ({pay_active, pay_last} !== 2'b10) begin
      errors++;
      $display("FAIL single_beat1 got %b exp 10",
        {pay_active, pay_last});
    end
    pay_beat = 1'b1;
    cyc();
    #1;
    checks++;
    if ({pay_active, pay_last} !== 2'b11) begin
      errors++;
      $display("FAIL single_beat2 got %b exp 11",
        {pay_active, pay_last});
    end
    cyc();
    pay_beat = 1'b0;
    #1;
    checks++;
    if ({pay_active, hdr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle got %b exp 00",
        {pay_active, hdr_valid});
    end
    cyc();
  endtask

  task automatic test_zero_len();
    set_req1(16'h1234, 16'h5678, 16'h0000, 16'h9ABC);
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL zlen_rdy got %b exp 01",
        {req0_ready, req1_ready});
    end
    cyc();
    req1_valid = 1'b0;
    hdr_ready = 1'b1;
    #1;
    checks++;
    if (hdr_valid !== 1'b1 ||
        hdr_data !== 64'h1234_5678_0008_9ABC ||
        hdr_sel !== 1'b1 || pay_active !== 1'b0) begin
      errors++;
      $display("FAIL zlen_hdr got v=%b %h sel=%b pa=%b",
        hdr_valid, hdr_data, hdr_sel, pay_active);
    end
    cyc();
    hdr_ready = 1'b0;
    #1;
    checks++;
    if ({hdr_valid, pay_active} !== 2'b00) begin
      errors++;
      $display("FAIL zlen_idle got %b exp 00",
        {hdr_valid, pay_active});
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic exp_g;
    set_req0(16'h0A0A, 16'h0B0B, 16'h0000, 16'h0C0C);
    set_req1(16'h1A1A, 16'h1B1B, 16'h0000, 16'h1C1C);
    req0_valid = 1'b1; req1_valid = 1'b1;
    hdr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) begin
        errors++;
        $display("FAIL rr_grant k=%0d got %b exp %b", k,
          {req0_ready, req1_ready}, {~exp_g, exp_g});
      end
      cyc();
      #1;
      checks++;
      if (hdr_valid !== 1'b1 || hdr_sel !== exp_g) begin
        errors++;
        $display("FAIL rr_sel k=%0d got v=%b sel=%b exp 1 %b",
          k, hdr_valid, hdr_sel, exp_g);
      end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    hdr_ready = 1'b0;
    cyc();
  endtask

  task automatic test_oversize_hold();
    set_req0(16'hDEAD, 16'hBEEF, 16'hFFF0, 16'h0001);
    req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovr_rdy got %b exp 1", req0_ready);
    end
    cyc();
    set_req0(16'h4444, 16'h5555, 16'h0010, 16'h6666);
    set_req1(16'h1111, 16'h2222, 16'h0005, 16'h3333);
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({err_len, hdr_valid, req0_ready, req1_ready}
        !== 4'b1001) begin
      errors++;
      $display("FAIL ovr_err got %b exp 1001",
        {err_len, hdr_valid, req0_ready, req1_ready});
    end
    cyc();
    req1_valid = 1'b0;
    #1;
    checks++;
    if ({err_len, hdr_valid} !== 2'b01) begin
      errors++;
      $display("FAIL ovr_once got %b exp 01",
        {err_len, hdr_valid});
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (hdr_data !== 64'h1111_2222_000D_3333 ||
          req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold i=%0d got %h r0=%b", i,
          hdr_data, req0_ready);
      end
      cyc();
      #1;
    end
    hdr_ready = 1'b1;
    cyc();
    hdr_ready = 1'b0;
    #1;
    checks++;
    if ({pay_active, pay_last, req0_ready} !== 3'b110) begin
      errors++;
      $display("FAIL hold_pay got %b exp 110",
        {pay_active, pay_last, req0_ready});
    end
    pay_beat = 1'b1;
    cyc();
    pay_beat = 1'b0;
    #1;
    checks++;
    if ({pay_active, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_after got %b exp 01",
        {pay_active, req0_ready});
    end
    req0_valid = 1'b0;
    cyc();
  endtask

  task automatic test_max_len();
    set_req0(16'h7777, 16'h8888, MAXL, 16'h9999);
    req0_valid = 1'b1;
    #1;
    cyc();
    req0_valid = 1'b0;
    #1;
    checks++;
    if (err_len !== 1'b0 || hdr_valid !== 1'b1 ||
        hdr_data[31:16] !== 16'h05C8) begin
      errors++;
      $display("FAIL max_hdr got e=%b v=%b len=%h exp 0 1 05c8",
        err_len, hdr_valid, hdr_data[31:16]);
    end
    hdr_ready = 1'b1;
    cyc();
    hdr_ready = 1'b0;
    pay_beat = 1'b1;
    for (int i = 0; i < 184; i++) begin
      #1;
      checks++;
      if (pay_active !== 1'b1 || pay_last !== (i == 183)) begin
        errors++;
        $display("FAIL max_beat i=%0d got pa=%b pl=%b",
          i, pay_active, pay_last);
      end
      cyc();
    end
    pay_beat = 1'b0;
    #1;
    checks++;
    if (pay_active !== 1'b0) begin
      errors++;
      $display("FAIL max_end got %b exp 0", pay_active);
    end
    cyc();
  endtask

  task automatic test_reset_mid_pay();
    set_req0(16'h0101, 16'h0202, 16'h0018, 16'h0303);
    req0_valid = 1'b1;
    #1;
    cyc();
    req0_valid = 1'b0;
    hdr_ready = 1'b1;
    cyc();
    hdr_ready = 1'b0;
    #1;
    checks++;
    if ({pay_active, pay_last} !== 2'b10) begin
      errors++;
      $display("FAIL rstp_pre got %b exp 10",
        {pay_active, pay_last});
    end
    set_req0(16'h0A00, 16'h0B00, 16'h0000, 16'h0C00);
    set_req1(16'h1A00, 16'h1B00, 16'h0000, 16'h1C00);
    req0_valid = 1'b1; req1_valid = 1'b1;
    pay_beat = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, hdr_valid, hdr_sel,
         pay_active, pay_last, err_len} !== 7'b0 ||
        hdr_data !== 64'h0) begin
      errors++;
      $display("FAIL rstp_zero got %b %h exp 0",
        {req0_ready, req1_ready, hdr_valid, hdr_sel,
         pay_active, pay_last, err_len}, hdr_data);
    end
    cyc();
    pay_beat = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, pay_active, err_len}
        !== 4'b1000) begin
      errors++;
      $display("FAIL rstp_first got %b exp 1000",
        {req0_ready, req1_ready, pay_active, err_len});
    end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    hdr_ready = 1'b1;
    cyc();
    hdr_ready = 1'b0;
    cyc();
  endtask

  bit          rv [2];
  logic [15:0] rs [2], rd [2], rl [2], rc [2];
  bit          m_hdr, m_err, m_sel;
  int          m_beats, m_last;
  logic [15:0] m_src, m_dst, m_len, m_csum;

  function automatic logic [15:0] rand_len();
    int k;
    k = $urandom_range(9);
    if (k == 0) return 16'h0000;
    if (k == 1) return 16'($urandom_range(65535, int'(MAXL) + 1));
    if (k == 2) return MAXL;
    return 16'($urandom_range(200, 1));
  endfunction

  task automatic model_reset();
    m_hdr = 0; m_err = 0; m_sel = 0;
    m_beats = 0; m_last = 1;
  endtask

  task automatic test_random();
    int          g;
    bit          idle;
    logic [15:0] l8;
    logic [63:0] exp_hd;
    model_reset();
    rv[0] = 0; rv[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b0;
        #1;
        checks++;
        if ({hdr_valid, pay_active, err_len,
             req0_ready, req1_ready} !== 5'b0) begin
          errors++;
          $display("FAIL rnd_rst got %b exp 0", {hdr_valid,
            pay_active, err_len, req0_ready, req1_ready});
        end
        cyc();
        rst = 1'b1;
        model_reset();
      end
      for (int n = 0; n < 2; n++) begin
        if (!rv[n] && $urandom_range(2) == 0) begin
          rv[n] = 1;
          rs[n] = 16'($urandom);
          rd[n] = 16'($urandom);
          rl[n] = rand_len();
          rc[n] = 16'($urandom);
        end
      end
      req0_valid = rv[0];
      req1_valid = rv[1];
      set_req0(rs[0], rd[0], rl[0], rc[0]);
      set_req1(rs[1], rd[1], rl[1], rc[1]);
      hdr_ready = 1'($urandom_range(1));
      pay_beat = ($urandom_range(4) < 3);
      #1;
      idle = !m_hdr && m_beats == 0;
      g = -1;
      if (idle) begin
        if (rv[0] && rv[1]) g = (m_last == 0) ? 1 : 0;
        else if (rv[0]) g = 0;
        else if (rv[1]) g = 1;
      end
      l8 = m_len + 16'd8;
      exp_hd = m_hdr ? {m_src, m_dst, l8, m_csum} : 64'h0;
      checks++;
      if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
        errors++;
        $display("FAIL rnd_rdy i=%0d got %b exp %b", i,
          {req0_ready, req1_ready}, {g == 0, g == 1});
      end
      checks++;
      if (hdr_valid !== m_hdr || hdr_data !== exp_hd) begin
        errors++;
        $display("FAIL rnd_hdr i=%0d got %b %h exp %b %h", i,
          hdr_valid, hdr_data, m_hdr, exp_hd);
      end
      checks++;
      if (pay_active !== (m_beats > 0) ||
          pay_last !== (m_beats == 1)) begin
        errors++;
        $display("FAIL rnd_pay i=%0d got %b%b beats_left %0d",
          i, pay_active, pay_last, m_beats);
      end
      checks++;
      if (err_len !== m_err || hdr_sel !== m_sel) begin
        errors++;
        $display("FAIL rnd_err_sel i=%0d got %b%b exp %b%b",
          i, err_len, hdr_sel, m_err, m_sel);
      end
      m_err = 0;
      if (g >= 0) begin
        m_src = rs[g]; m_dst = rd[g];
        m_len = rl[g]; m_csum = rc[g];
        m_sel = (g == 1);
        m_last = g;
        if (rl[g] > MAXL) m_err = 1;
        else m_hdr = 1;
        rv[g] = 0;
      end else if (m_hdr) begin
        if (hdr_ready) begin
          m_hdr = 0;
          m_beats = (int'(m_len) + 7) / 8;
        end
      end else if (m_beats > 0 && pay_beat) begin
        m_beats--;
      end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    hdr_ready = 1'b0; pay_beat = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    set_req0(16'h0, 16'h0, 16'h0, 16'h0);
    set_req1(16'h0, 16'h0, 16'h0, 16'h0);
    hdr_ready = 1'b0;
    pay_beat = 1'b0;
    test_reset();
    test_single();
    test_zero_len();
    test_round_robin();
    test_oversize_hold();
    test_max_len();
    test_reset_mid_pay();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
